// File: rtl/frame_seq_initiator.sv
// Framed bus initiator: queues requests and issues
// START / DATA / BE / END transfers back-to-back.
module frame_seq_initiator #(
  parameter int DATA_W     = 8,
  parameter int BE_W       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [0:BE_W-1]   req_be,
  output logic              start_sig,
  output logic              frame,
  output logic [DATA_W-1:0] data_bus,
  output logic [0:BE_W-1]   c_be,
  output logic              end_sig,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_BE,
    S_END
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [0:BE_W-1]   mem_be   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] hold_data;
  logic [0:BE_W-1]   hold_be;
  logic              push, pop, empty;

  assign req_ready = (count != FULL);
  assign empty     = (count == '0);
  assign push      = req_valid && req_ready;

  // Queue storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= req_data;
      mem_be[wr_ptr]   <= req_be;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register, hold registers and completed-transfer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_data <= '0;
      hold_be   <= '0;
      txn_count <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        hold_data <= mem_data[rd_ptr];
        hold_be   <= mem_be[rd_ptr];
      end
      if (state == S_END) txn_count <= txn_count + 1'b1;
    end
  end

  // Next-state logic; a pop loads the head into the hold registers
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          next_state = S_START;
          pop        = 1'b1;
        end
      end
      S_START: next_state = S_DATA;
      S_DATA:  next_state = S_BE;
      S_BE:    next_state = S_END;
      S_END: begin
        if (!empty) begin
          next_state = S_START;
          pop        = 1'b1;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Bus outputs decoded from state and hold registers only
  always_comb begin
    start_sig = 1'b0;
    frame     = 1'b1;
    data_bus  = '0;
    c_be      = '0;
    end_sig   = 1'b0;
    busy      = (state != S_IDLE);
    if (state != S_IDLE) data_bus = hold_data;
    unique case (state)
      S_START: start_sig = 1'b1;
      S_DATA:  frame     = 1'b0;
      S_BE:    c_be      = hold_be;
      S_END:   end_sig   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frame_seq_initiator.sv
// Randomised bench for frame_seq_initiator with a
// queue-based transfer model checked every cycle.
module tb_frame_seq_initiator;

  localparam int DATA_W = 8;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_data = '0;
  logic [0:BE_W-1]   req_be = '0;
  logic              start_sig, frame, end_sig, busy;
  logic [DATA_W-1:0] data_bus;
  logic [0:BE_W-1]   c_be;
  logic [CNT_W-1:0]  txn_count;

  always #5 clk = ~clk;

  frame_seq_initiator #(
    .DATA_W(DATA_W), .BE_W(BE_W),
    .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_be(req_be),
    .start_sig(start_sig), .frame(frame),
    .data_bus(data_bus), .c_be(c_be),
    .end_sig(end_sig), .busy(busy),
    .txn_count(txn_count)
  );

  // Framing order on the bus
  assert property (@(posedge clk) disable iff (rst)
    start_sig |=> (!frame && busy) ##1 (frame && !end_sig) ##1 end_sig);

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [0:BE_W-1]   be;
  } req_t;

  // Model: pending queue, current transfer, cycle within transfer
  req_t             q[$];
  req_t             cur;
  int               pos;
  logic [CNT_W-1:0] cnt;
  int               done;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos    = 0;
    cnt    = '0;
    cur.d  = '0;
    cur.be = '0;
  endtask

  task automatic check_outputs();
    chk("start", 32'(start_sig), 32'(pos == 1));
    chk("frame", 32'(frame), 32'(pos != 2));
    chk("data", 32'(data_bus), (pos != 0) ? 32'(cur.d) : 32'd0);
    chk("cbe", 32'(c_be), (pos == 3) ? 32'(cur.be) : 32'd0);
    chk("end", 32'(end_sig), 32'(pos == 4));
    chk("busy", 32'(busy), 32'(pos != 0));
    chk("count", 32'(txn_count), 32'(cnt));
    chk("ready", 32'(req_ready), 32'(q.size() < DEPTH));
  endtask

  // One clock: drive, advance model at the edge, check at negedge
  task automatic step(input logic v,
                      input logic [DATA_W-1:0] d,
                      input logic [0:BE_W-1] be,
                      output bit acc);
    req_t r;
    req_valid = v;
    req_data  = d;
    req_be    = be;
    acc = v && (q.size() < DEPTH);
    r.d  = d;
    r.be = be;
    @(posedge clk);
    if (pos == 4) begin
      cnt++;
      done++;
    end
    if ((pos == 0 || pos == 4) && q.size() > 0) begin
      cur = q.pop_front();
      pos = 1;
    end else if (pos == 4) begin
      pos = 0;
    end else if (pos != 0) begin
      pos++;
    end
    if (acc) q.push_back(r);
    @(negedge clk);
    check_outputs();
    req_valid = 1'b0;
  endtask

  bit acc;
  int idx;

  initial begin
    model_reset();
    done = 0;
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, acc);

    // Single transfer
    step(1'b1, 8'hA5, 4'b1010, acc);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, acc);

    // Five requests pushed with valid held until accepted
    idx = 0;
    for (int i = 0; i < 60 && idx < 5; i++) begin
      step(1'b1, 8'(idx + 1), 4'(idx + 3), acc);
      if (acc) idx++;
    end
    chk("burst_accepted", 32'(idx), 32'd5);
    for (int i = 0; i < 24; i++) step(1'b0, '0, '0, acc);

    // Fill the queue and offer a push on the END/pop edge
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 4'hF, acc);
    for (int i = 0; i < 20 && pos != 4; i++) step(1'b0, '0, '0, acc);
    step(1'b1, 8'hEE, 4'h1, acc);
    for (int i = 0; i < 24; i++) step(1'b0, '0, '0, acc);

    // Reset during the DATA cycle of a transfer
    step(1'b1, 8'h3C, 4'b0110, acc);
    for (int i = 0; i < 10 && pos != 2; i++) step(1'b0, '0, '0, acc);
    chk("reached_data", 32'(frame), 32'd0);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, acc);

    // Random traffic long enough to wrap the transfer counter
    done = 0;
    for (int i = 0; i < 4000 && done < 300; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom),
           4'($urandom), acc);
    chk("random_done", 32'(done >= 300), 32'd1);
    for (int i = 0; i < 24; i++) step(1'b0, '0, '0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
